axil_slave_regs: RTL

AXIL_SLAVE_REGS -- requirements
Module: axil_slave_regs

---
 rtl/axil_slave_regs.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_slave_regs.sv
// -----------------------------------------------------------------------------
// axil_slave_regs
//   AXI4-Lite slave with a small register file:
//     0x00 CTRL     RW   (drives ctrl_out directly)
//     0x04 SCRATCH  RW
//     0x08 STATUS   RO   (live status_in, sampled when the read is accepted)
//     0x0C EVENT    W1C  (sticky capture of event_in pulses, optional clear-on-read)
//   Addresses 0x10 and above answer SLVERR; reads of them return zero.
//
// Ports
//   AXI_ACLK, AXI_ARESETN     clock, asynchronous active-low reset
//   AXI_AW*/AXI_W*/AXI_B*     write address / data / response channels
//   AXI_AR*/AXI_R*            read address / data channels
//   ctrl_out                  current CTRL register value
//   status_in                 live status word
//   event_in                  per-bit single-cycle event pulses
// -----------------------------------------------------------------------------
module axil_slave_regs #(
  parameter int C_AXI_DATA_WIDTH     = 32,
  parameter int C_AXI_ADDR_WIDTH     = 8,
  parameter int OPT_READ_SIDEEFFECTS = 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  // write address
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
  input  logic [2:0]                  AXI_AWPROT,
  input  logic                        AXI_AWVALID,
  output logic                        AXI_AWREADY,
  // write data
  input  logic [31:0]                 AXI_WDATA,
  input  logic [3:0]                  AXI_WSTRB,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  // write response
  output logic [1:0]                  AXI_BRESP,
  output logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  // read address
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  // read data
  output logic [31:0]                 AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY,
  // user side
  output logic [31:0]                 ctrl_out,
  input  logic [31:0]                 status_in,
  input  logic [31:0]                 event_in
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_SCRATCH = 2'd1;
  localparam logic [1:0] IDX_STATUS  = 2'd2;
  localparam logic [1:0] IDX_EVENT   = 2'd3;

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] event_q, event_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // Both READYs are the same combinational term, so they pulse together. Once
  // accepted, BVALID rises and blocks further accepts, which makes the pulse
  // exactly one cycle. Gated by the reset pin so nothing is offered in reset.
  logic wr_accept;
  assign wr_accept   = AXI_AWVALID && AXI_WVALID && !bvalid_q && AXI_ARESETN;
  assign AXI_AWREADY = wr_accept;
  assign AXI_WREADY  = wr_accept;

  logic       wr_mapped;
  logic [1:0] wr_idx;
  assign wr_mapped = (AXI_AWADDR[C_AXI_ADDR_WIDTH-1:4] == '0);
  assign wr_idx    = AXI_AWADDR[3:2];

  // Expand WSTRB into a 32-bit lane mask.
  logic [31:0] wstrb_mask;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wstrb_mask[gi*8 +: 8] = {8{AXI_WSTRB[gi]}};
    end
  endgenerate

  logic [31:0] wr_merge_ctrl, wr_merge_scratch, wr_clr_bits;
  assign wr_merge_ctrl    = (ctrl_q & ~wstrb_mask) | (AXI_WDATA & wstrb_mask);
  assign wr_merge_scratch = (scratch_q & ~wstrb_mask) | (AXI_WDATA & wstrb_mask);
  assign wr_clr_bits      = (wr_accept && wr_mapped && (wr_idx == IDX_EVENT))
                            ? (AXI_WDATA & wstrb_mask) : 32'h0;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic rd_accept;
  assign AXI_ARREADY = !rvalid_q;
  assign rd_accept   = AXI_ARVALID && !rvalid_q;

  logic       rd_mapped;
  logic [1:0] rd_idx;
  assign rd_mapped = (AXI_ARADDR[C_AXI_ADDR_WIDTH-1:4] == '0);
  assign rd_idx    = AXI_ARADDR[3:2];

  logic [31:0] rd_word;
  always_comb begin
    rd_word = 32'h0;
    if (rd_mapped) begin
      case (rd_idx)
        IDX_CTRL:    rd_word = ctrl_q;
        IDX_SCRATCH: rd_word = scratch_q;
        IDX_STATUS:  rd_word = status_in;
        default:     rd_word = event_q;
      endcase
    end
  end

  // Clear-on-read removes exactly the bits being returned.
  logic [31:0] rd_clr_bits;
  assign rd_clr_bits = ((OPT_READ_SIDEEFFECTS != 0) && rd_accept && rd_mapped
                        && (rd_idx == IDX_EVENT)) ? event_q : 32'h0;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (wr_accept && wr_mapped) begin
      case (wr_idx)
        IDX_CTRL:    ctrl_d    = wr_merge_ctrl;
        IDX_SCRATCH: scratch_d = wr_merge_scratch;
        default:     ;  // STATUS ignored, EVENT handled below
      endcase
    end

    // New events are ORed in last so a same-cycle set beats any clear.
    event_d = (event_q & ~wr_clr_bits & ~rd_clr_bits) | event_in;

    if (wr_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (rd_accept) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      ctrl_q    <= 32'h0;
      scratch_q <= 32'h0;
      event_q   <= 32'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      event_q   <= event_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign AXI_BVALID = bvalid_q;
  assign AXI_BRESP  = bresp_q;
  assign AXI_RVALID = rvalid_q;
  assign AXI_RRESP  = rresp_q;
  assign AXI_RDATA  = rdata_q;
  assign ctrl_out   = ctrl_q;

endmodule
